// File: rtl/result_uart_tx.sv
// Sweeps a DRAM address range after the processor finishes and sends each byte
// out as an 8N1 UART frame, LSB first.
module result_uart_tx #(
   parameter int          CLKS_PER_BIT = 434,
   parameter logic [15:0] START_ADDR   = 16'd0,
   parameter logic [15:0] NUM_BYTES    = 16'd9
) (
   input  logic        clock,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  dm_q,
   output logic [15:0] rd_addr,
   output logic        busy,
   output logic        done,
   output logic        tx
);

   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR,
      S_WAIT,
      S_LOAD,
      S_START_BIT,
      S_DATA,
      S_STOP_BIT,
      S_NEXT,
      S_DONE
   } state_t;

   state_t      state;
   logic [15:0] baud_cnt;
   logic [15:0] count;
   logic [2:0]  bit_idx;
   logic [7:0]  shift;

   // tx is registered from the current state, so the line trails the state by
   // one cycle; every bit still lasts exactly CLKS_PER_BIT cycles.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         tx       <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         rd_addr  <= START_ADDR;
         count    <= 16'd0;
         baud_cnt <= 16'd0;
         bit_idx  <= 3'd0;
         shift    <= 8'd0;
      end else begin
         tx <= 1'b1;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state   <= S_ADDR;
                  busy    <= 1'b1;
                  done    <= 1'b0;
                  rd_addr <= START_ADDR;
                  count   <= 16'd0;
               end
            end
            S_ADDR: state <= S_WAIT;
            S_WAIT: state <= S_LOAD;
            S_LOAD: begin
               shift    <= dm_q;
               baud_cnt <= 16'd0;
               state    <= S_START_BIT;
            end
            S_START_BIT: begin
               tx <= 1'b0;
               if (baud_cnt == BAUD_LAST) begin
                  baud_cnt <= 16'd0;
                  bit_idx  <= 3'd0;
                  state    <= S_DATA;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            S_DATA: begin
               tx <= shift[0];
               if (baud_cnt == BAUD_LAST) begin
                  baud_cnt <= 16'd0;
                  shift    <= {1'b0, shift[7:1]};
                  if (bit_idx == 3'd7) begin
                     state <= S_STOP_BIT;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            S_STOP_BIT: begin
               if (baud_cnt == BAUD_LAST) begin
                  baud_cnt <= 16'd0;
                  state    <= S_NEXT;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            S_NEXT: begin
               count <= count + 16'd1;
               // The address is left on the last byte so a dump ending at
               // 16'hFFFF never wraps.
               if (count + 16'd1 == NUM_BYTES) begin
                  busy  <= 1'b0;
                  state <= S_DONE;
               end else begin
                  rd_addr <= rd_addr + 16'd1;
                  state   <= S_ADDR;
               end
            end
            S_DONE: begin
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: three instances with different address ranges
// share one DRAM model; tx traces are checked against an arithmetic frame model.
module tb_result_uart_tx;

   localparam int CPB      = 4;
   localparam int BYTE_CYC = 10 * CPB + 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  start_v = 3'b000;
   logic [7:0]  mem [256];
   logic [7:0]  q_a, q_b, q_c;
   logic [15:0] addr_a, addr_b, addr_c;
   logic        busy_a, busy_b, busy_c;
   logic        done_a, done_b, done_c;
   logic        tx_a, tx_b, tx_c;

   wire [2:0] tx_v   = {tx_c, tx_b, tx_a};
   wire [2:0] busy_v = {busy_c, busy_b, busy_a};
   wire [2:0] done_v = {done_c, done_b, done_a};

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0]  exp_q[$];
   logic        tx_tr[$];
   logic        done_tr[$];
   logic        busy_tr[$];
   logic [15:0] addr_tr[$];

   always #5 clk = ~clk;

   // DRAM with a registered address
   always_ff @(posedge clk) begin
      q_a <= mem[addr_a[7:0]];
      q_b <= mem[addr_b[7:0]];
      q_c <= mem[addr_c[7:0]];
   end

   result_uart_tx #(.CLKS_PER_BIT(CPB), .START_ADDR(16'h0000), .NUM_BYTES(16'd1)) u_a (
      .clock(clk), .rst(rst), .start(start_v[0]), .dm_q(q_a),
      .rd_addr(addr_a), .busy(busy_a), .done(done_a), .tx(tx_a));

   result_uart_tx #(.CLKS_PER_BIT(CPB), .START_ADDR(16'h0010), .NUM_BYTES(16'd9)) u_b (
      .clock(clk), .rst(rst), .start(start_v[1]), .dm_q(q_b),
      .rd_addr(addr_b), .busy(busy_b), .done(done_b), .tx(tx_b));

   result_uart_tx #(.CLKS_PER_BIT(CPB), .START_ADDR(16'h0020), .NUM_BYTES(16'd2)) u_c (
      .clock(clk), .rst(rst), .start(start_v[2]), .dm_q(q_c),
      .rd_addr(addr_c), .busy(busy_c), .done(done_c), .tx(tx_c));

   function automatic logic [15:0] addr_of(input int k);
      case (k)
         0:       return addr_a;
         1:       return addr_b;
         default: return addr_c;
      endcase
   endfunction

   // Expected line level idx cycles after the accepted start; dumps repeat
   // every nb*BYTE_CYC+2 cycles when start is held high.
   function automatic logic exp_tx(input int idx, input int nb);
      int p, j, o;
      logic [9:0] frame;
      p = idx % (nb * BYTE_CYC + 2);
      j = p / BYTE_CYC;
      o = p % BYTE_CYC;
      if (j >= nb || o < CPB) return 1'b1;
      frame = {1'b1, exp_q[j], 1'b0};
      return frame[(o - CPB) / CPB];
   endfunction

   // Mid-bit sampling of the captured tx trace for byte j.
   function automatic logic [7:0] decode(input int j);
      logic [7:0] d;
      for (int b = 0; b < 8; b++)
         d[b] = tx_tr[BYTE_CYC * j + CPB + CPB * (b + 1) + CPB / 2];
      return d;
   endfunction

   function automatic int first_done();
      for (int i = 0; i < done_tr.size(); i++)
         if (done_tr[i] === 1'b1) return i;
      return -1;
   endfunction

   // Entry i of each trace is sampled just after the i-th edge following the
   // accepting edge (entry 0 is just after the accepting edge itself).
   task automatic capture(input int k, input int ncyc, input bit hold, input int extra_at);
      tx_tr.delete(); done_tr.delete(); busy_tr.delete(); addr_tr.delete();
      @(negedge clk);
      start_v[k] = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) start_v[k] = 1'b0;
      for (int i = 0; i < ncyc; i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
         end
         if (extra_at >= 0 && i == extra_at) start_v[k] = 1'b1;
         else if (extra_at >= 0 && i == extra_at + 1) start_v[k] = 1'b0;
         tx_tr.push_back(tx_v[k]);
         done_tr.push_back(done_v[k]);
         busy_tr.push_back(busy_v[k]);
         addr_tr.push_back(addr_of(k));
      end
   endtask

   task automatic test_reset();
      int bad;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (tx_a !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx_a); else n_pass++;
      n_checks++;
      if (busy_v !== 3'b000) $display("FAIL reset_busy: got %b want 000", busy_v); else n_pass++;
      n_checks++;
      if (done_v !== 3'b000) $display("FAIL reset_done: got %b want 000", done_v); else n_pass++;
      n_checks++;
      if (addr_a !== 16'h0000 || addr_b !== 16'h0010)
         $display("FAIL reset_addr: got %h/%h want 0000/0010", addr_a, addr_b);
      else n_pass++;

      mem[0] = 8'h00;
      @(negedge clk);
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      n_checks++;
      if (tx_a !== 1'b0 || busy_a !== 1'b1)
         $display("FAIL pre_reset_data: got tx=%b busy=%b want tx=0 busy=1", tx_a, busy_a);
      else n_pass++;
      rst = 1'b1;
      #1;
      n_checks++;
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0 || addr_a !== 16'h0000)
         $display("FAIL mid_data_reset: got tx=%b busy=%b done=%b addr=%h want 1 0 0 0000",
                  tx_a, busy_a, done_a, addr_a);
      else n_pass++;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) $display("FAIL post_reset_quiet: got %0d active cycles want 0", bad); else n_pass++;
   endtask

   task automatic run_single(input logic [7:0] b);
      int lat, mism;
      mem[0] = b;
      exp_q.delete();
      exp_q.push_back(b);
      capture(0, 60, 1'b0, -1);
      lat = first_done();
      n_checks++;
      if (lat != BYTE_CYC + 1) $display("FAIL single_latency: got %0d want %0d", lat, BYTE_CYC + 1);
      else n_pass++;
      mism = 0;
      for (int i = 0; i < BYTE_CYC + 2; i++)
         if (tx_tr[i] !== exp_tx(i, 1)) mism++;
      n_checks++;
      if (mism != 0) $display("FAIL single_tx_trace: got %0d wrong cycles want 0 (byte %h)", mism, b);
      else n_pass++;
      n_checks++;
      if (decode(0) !== b) $display("FAIL single_decode: got %h want %h", decode(0), b); else n_pass++;
   endtask

   task automatic test_single_byte();
      run_single(8'hA5);
      run_single(8'($urandom_range(0, 255)));
   endtask

   task automatic test_multi_byte();
      int lat, mism;
      logic [15:0] seen[$];
      exp_q.delete();
      for (int i = 0; i < 9; i++) begin
         mem[16 + i] = 8'(i + 1);
         exp_q.push_back(8'(i + 1));
      end
      capture(1, 420, 1'b0, -1);
      lat = first_done();
      n_checks++;
      if (lat != 9 * BYTE_CYC + 1) $display("FAIL multi_latency: got %0d want %0d", lat, 9 * BYTE_CYC + 1);
      else n_pass++;
      mism = 0;
      for (int i = 0; i < 9 * BYTE_CYC + 2; i++)
         if (tx_tr[i] !== exp_tx(i, 9)) mism++;
      n_checks++;
      if (mism != 0) $display("FAIL multi_tx_trace: got %0d wrong cycles want 0", mism); else n_pass++;
      mism = 0;
      for (int j = 0; j < 9; j++)
         if (decode(j) !== exp_q[j]) mism++;
      n_checks++;
      if (mism != 0) $display("FAIL multi_decode: got %0d wrong bytes want 0", mism); else n_pass++;
      for (int i = 0; i < addr_tr.size(); i++)
         if (busy_tr[i] === 1'b1 && (seen.size() == 0 || seen[$] !== addr_tr[i]))
            seen.push_back(addr_tr[i]);
      mism = (seen.size() == 9) ? 0 : 1;
      for (int i = 0; i < seen.size() && i < 9; i++)
         if (seen[i] !== 16'(16 + i)) mism++;
      n_checks++;
      if (mism != 0) $display("FAIL multi_addr_walk: got %0d addresses (%0d off) want 0010..0018",
                              seen.size(), mism);
      else n_pass++;
   endtask

   task automatic test_start_while_busy();
      int lat, mism;
      exp_q.delete();
      for (int i = 0; i < 9; i++) begin
         mem[16 + i] = 8'($urandom_range(0, 255));
         exp_q.push_back(mem[16 + i]);
      end
      capture(1, 420, 1'b0, 2 * BYTE_CYC + 20);
      lat = first_done();
      n_checks++;
      if (lat != 9 * BYTE_CYC + 1) $display("FAIL busy_start_latency: got %0d want %0d", lat, 9 * BYTE_CYC + 1);
      else n_pass++;
      mism = 0;
      for (int i = 0; i < 9 * BYTE_CYC + 2; i++)
         if (tx_tr[i] !== exp_tx(i, 9)) mism++;
      n_checks++;
      if (mism != 0) $display("FAIL busy_start_trace: got %0d wrong cycles want 0", mism); else n_pass++;
   endtask

   task automatic test_restart();
      int lat, mism;
      n_checks++;
      if (done_b !== 1'b1) $display("FAIL restart_done_held: got %b want 1", done_b); else n_pass++;
      capture(1, 420, 1'b0, -1);
      n_checks++;
      if (done_tr[0] !== 1'b0 || busy_tr[0] !== 1'b1)
         $display("FAIL restart_done_drop: got done=%b busy=%b want 0 1", done_tr[0], busy_tr[0]);
      else n_pass++;
      lat = first_done();
      n_checks++;
      if (lat != 9 * BYTE_CYC + 1) $display("FAIL restart_latency: got %0d want %0d", lat, 9 * BYTE_CYC + 1);
      else n_pass++;
      mism = 0;
      for (int i = 0; i < 9 * BYTE_CYC + 2; i++)
         if (tx_tr[i] !== exp_tx(i, 9)) mism++;
      n_checks++;
      if (mism != 0) $display("FAIL restart_trace: got %0d wrong cycles want 0", mism); else n_pass++;
   endtask

   task automatic test_held_start();
      int lat, mism, highs;
      localparam int DUMP = 2 * BYTE_CYC + 2;
      exp_q.delete();
      for (int i = 0; i < 2; i++) begin
         mem[32 + i] = 8'($urandom_range(0, 255));
         exp_q.push_back(mem[32 + i]);
      end
      capture(2, 200, 1'b1, -1);
      lat = first_done();
      n_checks++;
      if (lat != DUMP - 1) $display("FAIL held_first_done: got %0d want %0d", lat, DUMP - 1); else n_pass++;
      highs = 0;
      for (int i = 0; i < 2 * DUMP - 1; i++)
         if (done_tr[i] === 1'b1) highs++;
      n_checks++;
      if (highs != 1) $display("FAIL held_done_pulse: got %0d high cycles want 1", highs); else n_pass++;
      n_checks++;
      if (done_tr[2 * DUMP - 1] !== 1'b1) $display("FAIL held_second_done: got %b want 1", done_tr[2 * DUMP - 1]);
      else n_pass++;
      mism = 0;
      for (int i = 0; i < 2 * DUMP; i++)
         if (tx_tr[i] !== exp_tx(i, 2)) mism++;
      n_checks++;
      if (mism != 0) $display("FAIL held_tx_trace: got %0d wrong cycles want 0", mism); else n_pass++;
      @(negedge clk);
      start_v[2] = 1'b0;
      repeat (150) @(posedge clk);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
      test_reset();
      test_single_byte();
      test_multi_byte();
      test_start_while_busy();
      test_restart();
      test_held_start();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
